// File: rtl/step_pulse_decoder.sv
// step_pulse_decoder: rebuilds axis position, step period and direction from
// the CW/CCW step pulse pair. It also flags overlapping and runt pulses.
// Each channel is synchronised, qualified by a minimum high time and counted
// once per pulse, however long the pulse is held high.
module step_pulse_decoder #(
  parameter int SYNC_STAGES      = 2,
  parameter int MIN_PULSE_CYCLES = 2,
  parameter int PERIOD_W         = 32,
  parameter int STALL_CYCLES     = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CW,
  input  logic                CCW,
  input  logic                CW_polarity,
  input  logic                load,
  input  logic [31:0]         load_value,
  input  logic                clear_fault,
  output logic [31:0]         Location,
  output logic [31:0]         step_count,
  output logic [PERIOD_W-1:0] step_period,
  output logic                direction,
  output logic                moving,
  output logic                fault,
  output logic [1:0]          fault_code
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    WAIT_LOW = 2'd2
  } chan_state_e;

  // hi_cnt only has to hold values up to MIN_PULSE_CYCLES
  localparam int                 HC_W      = $clog2(MIN_PULSE_CYCLES + 1);
  localparam logic [HC_W-1:0]    MIN_CNT   = HC_W'(MIN_PULSE_CYCLES);
  localparam logic [PERIOD_W-1:0] STALL_CNT = PERIOD_W'(STALL_CYCLES);

  logic [1:0] chan_raw;   // bit 0 = CW, bit 1 = CCW
  logic [1:0] chan_s;     // synchronised channels
  logic [1:0] accept;     // one-cycle step acceptance per channel
  logic [1:0] runt;       // one-cycle runt detection per channel
  logic       overlap;

  assign chan_raw = {CCW, CW};
  assign overlap  = &chan_s;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      chan_state_e            state_q, state_d;
      logic [HC_W-1:0]        hi_cnt_q, hi_cnt_d;
      logic                   acc, rnt;

      assign chan_s[gi] = sync_q[SYNC_STAGES-1];
      assign accept[gi] = acc;
      assign runt[gi]   = rnt;

      // synchroniser chain for the asynchronous step input
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], chan_raw[gi]};
      end

      // channel FSM state and high-time counter
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q  <= IDLE;
          hi_cnt_q <= '0;
        end else begin
          state_q  <= state_d;
          hi_cnt_q <= hi_cnt_d;
        end
      end

      // pulse qualification; an overlap parks the channel until it goes low
      always_comb begin
        state_d  = state_q;
        hi_cnt_d = hi_cnt_q;
        acc      = 1'b0;
        rnt      = 1'b0;
        if (overlap) begin
          state_d  = WAIT_LOW;
          hi_cnt_d = '0;
        end else begin
          case (state_q)
            IDLE: begin
              if (chan_s[gi]) begin
                if (MIN_PULSE_CYCLES == 1) begin
                  acc     = 1'b1;
                  state_d = WAIT_LOW;
                end else begin
                  state_d  = QUAL;
                  hi_cnt_d = HC_W'(1);
                end
              end
            end
            QUAL: begin
              if (chan_s[gi]) begin
                if (hi_cnt_q + HC_W'(1) >= MIN_CNT) begin
                  acc      = 1'b1;
                  state_d  = WAIT_LOW;
                  hi_cnt_d = '0;
                end else begin
                  hi_cnt_d = hi_cnt_q + HC_W'(1);
                end
              end else begin
                rnt      = 1'b1;
                state_d  = IDLE;
                hi_cnt_d = '0;
              end
            end
            WAIT_LOW: begin
              if (!chan_s[gi]) state_d = IDLE;
            end
            default: begin
              state_d  = IDLE;
              hi_cnt_d = '0;
            end
          endcase
        end
      end
    end
  endgenerate

  // At most one channel can accept per cycle, because accepting needs the
  // other channel low.
  logic step_any, step_up;
  assign step_any = |accept;
  assign step_up  = accept[0] ? ~CW_polarity : CW_polarity;

  logic [31:0]         loc_q, cnt_q;
  logic                dir_q, moving_q;
  logic [PERIOD_W-1:0] period_q, pcnt_q, pcnt_sat;
  logic [1:0]          fault_q;

  assign pcnt_sat = (pcnt_q == '1) ? pcnt_q : pcnt_q + PERIOD_W'(1);

  // position, step count and direction; a load overrides a same-cycle step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loc_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      loc_q <= load_value;
    end else if (step_any) begin
      loc_q <= step_up ? loc_q + 32'd1 : loc_q - 32'd1;
      cnt_q <= cnt_q + 32'd1;
      dir_q <= step_up;
    end
  end

  // step period measurement and stall detection, independent of load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q   <= '0;
      period_q <= '0;
      moving_q <= 1'b0;
    end else if (step_any) begin
      period_q <= moving_q ? pcnt_sat : '0;
      pcnt_q   <= '0;
      moving_q <= 1'b1;
    end else begin
      pcnt_q <= pcnt_sat;
      if (pcnt_q >= STALL_CNT) begin
        moving_q <= 1'b0;
        period_q <= '0;
      end
    end
  end

  // sticky fault flags; a fresh event outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= '0;
    else      fault_q <= (clear_fault ? 2'b00 : fault_q) | {|runt, overlap};
  end

  assign Location    = loc_q;
  assign step_count  = cnt_q;
  assign step_period = period_q;
  assign direction   = dir_q;
  assign moving      = moving_q;
  assign fault_code  = fault_q;
  assign fault       = |fault_q;

endmodule

// File: tb/tb_step_pulse_decoder.sv
// Testbench for step_pulse_decoder: directed scenarios plus random pulse
// trains; a queue-based scoreboard checks every accepted step.
module tb_step_pulse_decoder;
  localparam int SYNC  = 2;
  localparam int MINP  = 2;
  localparam int PW    = 32;
  localparam int STALL = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          CW = 1'b0, CCW = 1'b0, pol = 1'b0, load = 1'b0, clear_fault = 1'b0;
  logic [31:0]   load_value = '0;
  logic [31:0]   Location, step_count;
  logic [PW-1:0] step_period;
  logic          direction, moving, fault;
  logic [1:0]    fault_code;

  step_pulse_decoder #(
    .SYNC_STAGES(SYNC), .MIN_PULSE_CYCLES(MINP), .PERIOD_W(PW), .STALL_CYCLES(STALL)
  ) dut (
    .clk(clk), .rst(rst), .CW(CW), .CCW(CCW), .CW_polarity(pol), .load(load),
    .load_value(load_value), .clear_fault(clear_fault), .Location(Location),
    .step_count(step_count), .step_period(step_period), .direction(direction),
    .moving(moving), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] loc;
    logic [31:0] cnt;
    logic        dir;
    logic [31:0] per;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  // reference model: position/count/direction plus time of the last accepted step
  logic [31:0] m_loc = '0, m_cnt = '0;
  logic        m_dir = 1'b0;
  int          m_last_t = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_loc = '0; m_cnt = '0; m_dir = 1'b0; m_last_t = -1;
  endtask

  // A step whose input rose at cycle t. Period is the spacing of rising edges
  // unless the axis had stalled (more than STALL+1 cycles since last step).
  task automatic model_step(input bit ch, input int t, input bit discarded);
    exp_t e;
    int   d;
    logic up;
    up = (ch == 1'b0) ? !pol : pol;
    d  = t - m_last_t;
    e.per = (m_last_t >= 0 && d <= STALL + 1) ? 32'(d) : 32'd0;
    m_last_t = t;
    if (!discarded) begin
      m_loc = up ? m_loc + 32'd1 : m_loc - 32'd1;
      m_cnt = m_cnt + 32'd1;
      m_dir = up;
      e.loc = m_loc; e.cnt = m_cnt; e.dir = m_dir;
      q.push_back(e);
    end
  endtask

  // called just after a rising edge; pulse high for w cycles then low for g
  task automatic drive_pulse(input bit ch, input int w, input int g);
    if (w >= MINP) model_step(ch, cyc, 1'b0);
    if (ch == 1'b0) CW = 1'b1; else CCW = 1'b1;
    repeat (w) @(posedge clk);
    #1; CW = 1'b0; CCW = 1'b0;
    repeat (g) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] v);
    load_value = v; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    m_loc = v;
    chk("load_loc", Location, v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_loc"}, Location, 32'd0);
    chk({tag, "_cnt"}, step_count, 32'd0);
    chk({tag, "_per"}, step_period, 32'd0);
    chk({tag, "_dir"}, direction, 32'd0);
    chk({tag, "_mov"}, moving, 32'd0);
    chk({tag, "_fc"}, fault_code, 32'd0);
    chk({tag, "_flt"}, fault, 32'd0);
  endtask

  // scoreboard monitor: every change of step_count is one accepted step
  logic [31:0] prev_cnt = '0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && step_count !== prev_cnt) begin
      if (q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_step: step_count %0d Location %0h, no step expected", step_count, Location);
      end else begin
        e = q.pop_front();
        chk("sb_loc", Location, e.loc);
        chk("sb_cnt", step_count, e.cnt);
        chk("sb_dir", direction, e.dir);
        chk("sb_per", step_period, e.per);
        chk("sb_mov", moving, 32'd1);
      end
    end
    prev_cnt = step_count;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p, d, ch, w, g;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // 10 CW pulses, 4 high / 20 period
    pol = 1'b0;
    repeat (10) drive_pulse(1'b0, 4, 16);
    drain();
    chk("t1_loc", Location, 32'd10);
    chk("t1_per", step_period, 32'd20);

    // load then CCW, then inverted polarity CW
    do_load(32'd1000);
    repeat (3) drive_pulse(1'b1, 3, 10);
    drain();
    chk("t2_loc_ccw", Location, 32'd997);
    pol = 1'b1;
    repeat (3) drive_pulse(1'b0, 3, 10);
    drain();
    chk("t2_loc_pol", Location, 32'd994);
    pol = 1'b0;

    // runt pulse
    drive_pulse(1'b0, 1, 10);
    chk("runt_fc", fault_code, 32'd2);
    chk("runt_loc", Location, m_loc);
    clear_fault = 1'b1; @(posedge clk); #1; clear_fault = 1'b0;
    chk("clr_flt", fault, 32'd0);
    chk("clr_fc", fault_code, 32'd0);

    // overlap for 5 cycles
    CW = 1'b1; CCW = 1'b1;
    repeat (5) @(posedge clk);
    #1; CW = 1'b0; CCW = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("ovl_fc", fault_code, 32'd1);
    chk("ovl_cnt", step_count, m_cnt);

    // clear coincident with a runt: overlap bit cleared, runt bit kept
    CW = 1'b1; @(posedge clk); #1; CW = 1'b0;
    repeat (2) @(posedge clk);
    #1; clear_fault = 1'b1;
    @(posedge clk); #1; clear_fault = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("clr_runt_fc", fault_code, 32'd2);
    drive_pulse(1'b0, 4, 10);
    drain();
    chk("post_fault_loc", Location, m_loc);

    // load in the same cycle a CCW step is accepted
    p = cyc;
    CCW = 1'b1;
    model_step(1'b1, p, 1'b1);
    repeat (3) @(posedge clk);
    #1; load_value = 32'h1234_5678; load = 1'b1;
    @(posedge clk); #1; load = 1'b0; CCW = 1'b0;
    m_loc = 32'h1234_5678;
    repeat (10) @(posedge clk);
    #1;
    chk("ldstep_loc", Location, 32'h1234_5678);
    chk("ldstep_cnt", step_count, m_cnt);
    chk("ldstep_dir", direction, m_dir);
    chk("ldstep_mov", moving, 32'd1);
    drive_pulse(1'b0, 4, 10);
    drain();

    // wrap, stall, first step after stall
    do_load(32'hFFFF_FFFF);
    drive_pulse(1'b0, 4, 10);
    drain();
    chk("wrap_loc", Location, 32'd0);
    repeat (STALL + 30) @(posedge clk);
    #1;
    chk("stall_mov", moving, 32'd0);
    chk("stall_per", step_period, 32'd0);
    drive_pulse(1'b0, 4, 10);
    drain();

    // random pulse trains
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) do_load($urandom);
      if (m_last_t >= 0) begin
        d = cyc - m_last_t;
        if (d >= STALL - 8 && d <= STALL + 12) begin
          repeat (25) @(posedge clk);
          #1;
        end
      end
      pol = 1'($urandom_range(0, 1));
      ch  = $urandom_range(0, 1);
      w   = ($urandom_range(0, 7) == 0) ? 1 : $urandom_range(2, 6);
      g   = ($urandom_range(0, 11) == 0) ? $urandom_range(130, 200) : $urandom_range(2, 40);
      drive_pulse(ch[0], w, g);
    end
    drain();
    chk("rand_loc", Location, m_loc);
    chk("rand_cnt", step_count, m_cnt);

    // reset mid-pulse, release with CW still high
    pol = 1'b0;
    CW = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    model_step(1'b0, cyc, 1'b0);
    repeat (20) @(posedge clk);
    #1; CW = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    drain();
    chk("rst_one_cnt", step_count, 32'd1);
    chk("rst_one_loc", Location, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/step_pulse_decoder.md
Name: step_pulse_decoder

Overview:
- Receives the CW/CCW step-pulse pair that the motor controller drives to the stepper driver. Reconstructs the axis position, the step period and the direction from those pulses.
- Used as an independent loopback monitor, per axis, on the FPGA fabric. Software compares its Location against the commanded Location and reads its measured speed.
- Flags malformed pulse trains, such as overlapping CW/CCW or runt pulses.

Parameters:
SYNC_STAGES, 2, flip-flop stages on CW and CCW before any logic (min 2)
MIN_PULSE_CYCLES, 2, consecutive synced-high clk cycles needed to accept a step (min 1)
PERIOD_W, 32, width of the period counter and step_period
STALL_CYCLES, 25000000, clk cycles with no accepted step before moving clears (0.5 s at 50 MHz)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous reset, active low
CW  in  1  step pulse, clockwise (asynchronous to clk)
CCW  in  1  step pulse, counter-clockwise (asynchronous to clk)
CW_polarity  in  1  0: CW step = +1, CCW step = -1; 1: inverted
load  in  1  one-cycle strobe, Location <= load_value
load_value  in  32  preset position (e.g. home_location after homing)
clear_fault  in  1  one-cycle strobe, clears fault and fault_code
Location  out  32  decoded position, two's-complement, wraps modulo 2^32
step_count  out  32  total accepted steps of either direction, wraps
step_period  out  PERIOD_W  clk cycles between the last two accepted steps; 0 = invalid
direction  out  1  1 = last accepted step was +1
moving  out  1  an accepted step occurred within STALL_CYCLES
fault  out  1  sticky, OR of fault_code bits
fault_code  out  2  sticky; bit0 = CW/CCW overlap, bit1 = runt pulse

Behaviour:
- Reset (rst low, asynchronous): every output and register is 0, including the sync chains, hi_cnt and the period counter. State is IDLE.
- Each channel is synchronised through SYNC_STAGES flops. Every later reference is to the synced signals cw_s and ccw_s.
- Each channel runs its own FSM with states IDLE, QUAL and WAIT_LOW.
  - IDLE: when the synced signal is high, go to QUAL with hi_cnt = 1. If MIN_PULSE_CYCLES = 1, accept immediately and go to WAIT_LOW.
  - QUAL: while high, hi_cnt++. On the edge where hi_cnt reaches MIN_PULSE_CYCLES, accept one step and go to WAIT_LOW. If low before that, set fault_code[1], count nothing and return to IDLE.
  - WAIT_LOW: stay until the synced signal is low, then go to IDLE. A pulse held high for a long time counts once.
- Overlap: on any cycle where cw_s and ccw_s are both high:
  - set fault_code[0];
  - move both FSMs to WAIT_LOW;
  - no step is accepted that cycle or for either pulse in progress.
- Accepted step, with sign from the channel and CW_polarity:
  - Location ± 1, wrapping;
  - step_count + 1;
  - direction updated;
  - moving <= 1.
- Latency: input high sampled at edge 1 → Location changes at edge SYNC_STAGES + MIN_PULSE_CYCLES (edge 4 with defaults).
- Period counter:
  - Increments every cycle and saturates at 2^PERIOD_W - 1.
  - On an accepted step: if moving was 1, step_period <= counter + 1; otherwise step_period <= 0 (first step after reset or stall). The counter then resets to 0.
  - Direction reversal does not invalidate the period.
- Stall: when the counter reaches STALL_CYCLES with no step: moving <= 0 and step_period <= 0.
- load:
  - Location <= load_value next edge.
  - A step accepted in the same cycle is discarded: Location, step_count and direction unchanged by it.
  - The FSMs continue normally.
  - Period logic and moving are unaffected.
- clear_fault clears both fault_code bits next edge. A new fault event in the same cycle wins, and that bit stays set.
- fault has no effect on counting. It is status only.

Test Plan:
1. Reset, CW_polarity = 0, 10 CW pulses (4 clk high, 20 clk period) → Location = 10, step_count = 10, direction = 1, step_period = 20, moving = 1.
2. load_value = 1000 with load, then 3 CCW pulses → Location = 997. With CW_polarity = 1, 3 CW pulses → Location = 994.
3. CW pulse 1 clk wide (synced) → fault_code = 2'b10, Location unchanged. clear_fault → fault = 0. clear_fault coincident with a new runt → fault_code = 2'b10.
4. CW and CCW high together for 5 clk → fault_code[0] = 1, no step counted. Then a clean CW pulse → Location + 1.
5. Location = 32'hFFFFFFFF, one CW step → 0. After STALL_CYCLES (override to 100) idle → moving = 0, step_period = 0. Next step → step_period still 0.
6. Assert rst mid-pulse (CW high, FSM in QUAL) → all outputs 0 immediately. Release with CW still high → exactly one step after SYNC + MIN edges.
